boruss_control_unit: RTL
========================

BORUSS_CONTROL_UNIT -- requirements
Module: boruss_control_unit

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction word width: opcode [15:8], immediate [7:0].
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous and active-high; one clock only.
REQ-003 SHALL have ports: start in 1, one-cycle pulse that leaves IDLE; busy out 1, high outside IDLE and HALTED; halted out 1, high in HALTED.
REQ-004 SHALL have ports: instr_addr out 8 (equals pc); instr_rd_en out 1; instr_data in INSTR_W, synchronous ROM data valid one cycle after instr_rd_en.
REQ-005 SHALL have ports: alu_operand_a out 8 (acc); alu_operand_b out 8 (IR immediate); alu_operation_code out 8 (IR opcode).
REQ-006 SHALL have ports: alu_result in 8; alu_zero_flag, alu_carry_flag, alu_negative_flag in 1 each, combinational from ALU.
REQ-007 SHALL have ports: pc out 8; acc out 8; flag_z, flag_c, flag_n out 1 each; illegal_op out 1; retired_count out 16.

Function
REQ-008 SHALL run FSM IDLE, FETCH, LOAD, EXEC, HALTED; 3 cycles per instruction.
REQ-009 IDLE->FETCH on start; start outside IDLE SHALL be ignored.
REQ-010 FETCH SHALL assert instr_rd_en for exactly one cycle -> LOAD.
REQ-011 LOAD SHALL latch instr_data into IR -> EXEC.
REQ-012 EXEC SHALL sample ALU outputs combinationally and commit all updates at the clock edge ending EXEC -> FETCH, or HALTED for HALT.
REQ-013 Opcodes 0x00-0x07 (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR): acc<=alu_result; Z/C/N<=ALU flags; pc<=pc+1.
REQ-014 0x0F CMP SHALL update Z/C/N only; acc unchanged; pc<=pc+1.
REQ-015 0x08 JMP SHALL set pc<=alu_result (the immediate).
REQ-016 Conditional jumps SHALL test latched flags, not ALU flags: 0x09 JZ (Z=1), 0x0A JNZ (Z=0), 0x0B JC (C=1), 0x0C JNC (C=0), 0x0D JN (N=1), 0x0E JNN (N=0).
REQ-017 Conditional jump: taken -> pc<=immediate, else pc<=pc+1; no jump SHALL modify flags or acc.
REQ-018 0x10 LDI SHALL set acc<=immediate; flags unchanged; pc<=pc+1.
REQ-019 0xFE HALT SHALL enter HALTED with pc held at the HALT address; only rst exits HALTED.
REQ-020 Any other opcode is illegal: illegal_op pulses high one cycle after EXEC; acc and flags unchanged.
REQ-021 pc+1 SHALL wrap 0xFF->0x00.
REQ-022 retired_count SHALL increment once per completed EXEC, including HALT and illegal opcodes, and wrap at 0xFFFF.
REQ-023 ALU output ports SHALL be continuous functions of acc and IR in every state.

Reset
REQ-024 rst in any state, mid-instruction included, SHALL force IDLE with pc=0, acc=0, IR=0, Z=C=N=0, illegal_op=0, retired_count=0, instr_rd_en=0, busy=0, halted=0.
REQ-025 rst SHALL take priority over start on the same edge.

Configuration
REQ-026 Macro BORUSS_ILLEGAL_TRAP_EN, when defined: an illegal opcode pulses illegal_op and enters HALTED with pc held.
REQ-027 Without BORUSS_ILLEGAL_TRAP_EN: an illegal opcode pulses illegal_op, executes as NOP with pc<=pc+1, and continues.

Structure
REQ-028 Package boruss_pkg SHALL hold opcode constants 0x00-0x10 and 0xFE, the FSM state enum, and the opcode/immediate field positions.
REQ-029 Sub-module boruss_branch_eval SHALL be combinational: in opcode, Z, C, N; out take.
REQ-030 The ALU SHALL be instantiated outside this block; its connection is by ports only.

Verification
REQ-031 ROM {LDI 0x0A, ADD 0x05, HALT}, start -> acc=0x0F, Z=C=N=0, halted=1, pc=2, retired_count=3 after 9 busy cycles.
REQ-032 {LDI 0xFF, ADD 0x01, JC 0x10}, ROM[0x10]=HALT -> acc=0x00, Z=1, C=1, pc=0x10, halted=1.
REQ-033 {LDI 0x05, CMP 0x0F, JNN 0x20, HALT} -> acc=0x05, C=1, N=1, JNN not taken, halted with pc=3.
REQ-034 JMP 0xFF at 0x00, ROM[0xFF]=ADD 0x00 -> pc wraps to 0x00 after ADD.
REQ-035 Opcode 0x11 at 0x00 -> illegal_op one-cycle pulse; with macro halted=1 and pc=0; without macro pc=1 and running.
REQ-036 rst asserted during LOAD -> next cycle IDLE, all outputs at reset values; start before rst is released is ignored.

Source files
------------

// File: rtl/boruss_pkg.sv
// Shared definitions for the BORUSS control unit: opcodes, FSM states, field positions.
package boruss_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RET_W   = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_NOT  = 8'h05;
  localparam logic [7:0] OP_SHL  = 8'h06;
  localparam logic [7:0] OP_SHR  = 8'h07;
  localparam logic [7:0] OP_JMP  = 8'h08;
  localparam logic [7:0] OP_JZ   = 8'h09;
  localparam logic [7:0] OP_JNZ  = 8'h0A;
  localparam logic [7:0] OP_JC   = 8'h0B;
  localparam logic [7:0] OP_JNC  = 8'h0C;
  localparam logic [7:0] OP_JN   = 8'h0D;
  localparam logic [7:0] OP_JNN  = 8'h0E;
  localparam logic [7:0] OP_CMP  = 8'h0F;
  localparam logic [7:0] OP_LDI  = 8'h10;
  localparam logic [7:0] OP_HALT = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // Arithmetic/logic opcodes whose result is written back to acc.
  function automatic logic is_alu_op(input logic [7:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/boruss_branch_eval.sv
// Conditional-jump decision from opcode and the latched Z/C/N flags (combinational).
module boruss_branch_eval
  import boruss_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic       z,
  input  logic       c,
  input  logic       n,
  output logic       take
);

  // Condition select; non-conditional opcodes never take.
  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_JZ:   take = z;
      OP_JNZ:  take = ~z;
      OP_JC:   take = c;
      OP_JNC:  take = ~c;
      OP_JN:   take = n;
      OP_JNN:  take = ~n;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/boruss_control_unit.sv
// BORUSS control unit: IDLE/FETCH/LOAD/EXEC/HALTED sequencer driving an external ALU.
// Optional feature: define BORUSS_ILLEGAL_TRAP_EN to halt on illegal opcodes
// (default: illegal opcodes execute as NOP and the program continues).
module boruss_control_unit
  import boruss_pkg::*;
#(
  parameter int unsigned INSTR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                halted,
  output logic [DATA_W-1:0]   instr_addr,
  output logic                instr_rd_en,
  input  logic [INSTR_W-1:0]  instr_data,
  output logic [DATA_W-1:0]   alu_operand_a,
  output logic [DATA_W-1:0]   alu_operand_b,
  output logic [DATA_W-1:0]   alu_operation_code,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero_flag,
  input  logic                alu_carry_flag,
  input  logic                alu_negative_flag,
  output logic [DATA_W-1:0]   pc,
  output logic [DATA_W-1:0]   acc,
  output logic                flag_z,
  output logic                flag_c,
  output logic                flag_n,
  output logic                illegal_op,
  output logic [RET_W-1:0]    retired_count
);

  state_t               r_state,   w_state_nxt;
  logic [DATA_W-1:0]    r_pc,      w_pc_nxt;
  logic [DATA_W-1:0]    r_acc,     w_acc_nxt;
  logic [INSTR_W-1:0]   r_ir,      w_ir_nxt;
  logic                 r_z,       w_z_nxt;
  logic                 r_c,       w_c_nxt;
  logic                 r_n,       w_n_nxt;
  logic                 r_illegal, w_illegal_nxt;
  logic [RET_W-1:0]     r_retired, w_retired_nxt;
  logic                 r_rd_en,   w_rd_en_nxt;
  logic                 r_busy,    w_busy_nxt;
  logic                 r_halted,  w_halted_nxt;

  logic [7:0]           w_opcode;
  logic [7:0]           w_imm;
  logic [DATA_W-1:0]    w_pc_inc;
  logic                 w_take;

  assign w_opcode = r_ir[OPC_MSB:OPC_LSB];
  assign w_imm    = r_ir[IMM_MSB:IMM_LSB];
  assign w_pc_inc = r_pc + DATA_W'(1);

  boruss_branch_eval u_branch_eval (
    .opcode (w_opcode),
    .z      (r_z),
    .c      (r_c),
    .n      (r_n),
    .take   (w_take)
  );

  // State and datapath registers; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_acc     <= '0;
      r_ir      <= '0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_n       <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_acc     <= w_acc_nxt;
      r_ir      <= w_ir_nxt;
      r_z       <= w_z_nxt;
      r_c       <= w_c_nxt;
      r_n       <= w_n_nxt;
      r_illegal <= w_illegal_nxt;
      r_retired <= w_retired_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_busy    <= w_busy_nxt;
      r_halted  <= w_halted_nxt;
    end
  end

  // Next-state and commit logic; status outputs are precomputed from the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_acc_nxt     = r_acc;
    w_ir_nxt      = r_ir;
    w_z_nxt       = r_z;
    w_c_nxt       = r_c;
    w_n_nxt       = r_n;
    w_illegal_nxt = 1'b0;
    w_retired_nxt = r_retired;

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_ir_nxt    = instr_data;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_retired_nxt = r_retired + RET_W'(1);
        w_state_nxt   = ST_FETCH;
        if (is_alu_op(w_opcode)) begin
          w_acc_nxt = alu_result;
          w_z_nxt   = alu_zero_flag;
          w_c_nxt   = alu_carry_flag;
          w_n_nxt   = alu_negative_flag;
          w_pc_nxt  = w_pc_inc;
        end else begin
          case (w_opcode)
            OP_CMP: begin
              w_z_nxt  = alu_zero_flag;
              w_c_nxt  = alu_carry_flag;
              w_n_nxt  = alu_negative_flag;
              w_pc_nxt = w_pc_inc;
            end
            OP_JMP: w_pc_nxt = alu_result;
            OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_JN, OP_JNN:
              w_pc_nxt = w_take ? w_imm : w_pc_inc;
            OP_LDI: begin
              w_acc_nxt = w_imm;
              w_pc_nxt  = w_pc_inc;
            end
            OP_HALT: w_state_nxt = ST_HALTED;
            default: begin
              w_illegal_nxt = 1'b1;
`ifdef BORUSS_ILLEGAL_TRAP_EN
              w_state_nxt   = ST_HALTED;
`else
              w_pc_nxt      = w_pc_inc;
`endif
            end
          endcase
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_rd_en_nxt  = (w_state_nxt == ST_FETCH);
    w_busy_nxt   = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HALTED);
    w_halted_nxt = (w_state_nxt == ST_HALTED);
  end

  // Output wiring; ALU operands follow acc and IR continuously.
  assign busy               = r_busy;
  assign halted             = r_halted;
  assign instr_addr         = r_pc;
  assign instr_rd_en        = r_rd_en;
  assign alu_operand_a      = r_acc;
  assign alu_operand_b      = w_imm;
  assign alu_operation_code = w_opcode;
  assign pc                 = r_pc;
  assign acc                = r_acc;
  assign flag_z             = r_z;
  assign flag_c             = r_c;
  assign flag_n             = r_n;
  assign illegal_op         = r_illegal;
  assign retired_count      = r_retired;

endmodule
